// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, exception codes, FSM states and redirect target helper.
package pipe_ctrl_pkg;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  // Interrupts and ERET have dedicated targets; every other code shares the exception vector.
  function automatic logic [31:0] exc_target(input logic [31:0] code, input logic [31:0] epc,
                                             input logic [31:0] int_vec, input logic [31:0] exc_vec);
    return code == EXC_INT ? int_vec : code == EXC_ERET ? epc : exc_vec;
  endfunction
endpackage

// File: rtl/pipe_ctrl_stall_monitor.sv
// stall_monitor: stall watchdog with one-cycle timeout pulse and saturating stalled-cycle counter.
module stall_monitor #(
  parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);
  logic [15:0] wdog;
  // The pulse fires during the stalled cycle that brings the count up to the limit.
  assign stall_timeout = active && wdog == WDOG_LIMIT - 16'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog         <= '0;
      stall_cycles <= '0;
    end else begin
      wdog <= (!active || stall_timeout) ? '0 : wdog + 16'd1;
      if (active && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with deferred exception handling behind memory stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);
  logic [1:0]  state, state_nx;
  logic [31:0] lat_code, lat_epc;
  logic        has_exc;
  logic [5:0]  req_stall;
  assign has_exc   = |excepttype_i;
  assign req_stall = stallreq_from_mem ? STALL_MEM : stallreq_from_ex ? STALL_EX :
                     stallreq_from_id ? STALL_ID : STALL_NONE;
  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = '0;
    state_nx = state;
    if (rst) begin
      state_nx = ST_RUN;
    end else if (state == ST_RUN) begin
      if (has_exc && !stallreq_from_mem) begin
        flush    = 1'b1;
        new_pc   = exc_target(excepttype_i, cp0_epc_i, INT_VECTOR, EXC_VECTOR);
        state_nx = ST_FLUSH;
      end else if (has_exc) begin
        stall    = STALL_MEM;
        state_nx = ST_PEND;
      end else begin
        stall = req_stall;
      end
    end else if (state == ST_PEND) begin
      if (stallreq_from_mem) begin
        stall = STALL_MEM;
      end else begin
        flush    = 1'b1;
        new_pc   = exc_target(lat_code, lat_epc, INT_VECTOR, EXC_VECTOR);
        state_nx = ST_FLUSH;
      end
    end else begin
      state_nx = ST_RUN;
    end
  end
  // EPC is captured on entry so a later CP0 write cannot move the ERET target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      lat_code <= '0;
      lat_epc  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_RUN && has_exc && stallreq_from_mem) begin
        lat_code <= excepttype_i;
        lat_epc  <= cp0_epc_i;
      end
    end
  end
  stall_monitor #(.WDOG_LIMIT(WDOG_LIMIT)) u_mon (
    .clk          (clk),
    .rst          (rst),
    .active       (|stall),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl stall priority, exception redirect, PEND/FLUSH and watchdog.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id = 1'b0, ex = 1'b0, mem = 1'b0;
  logic [31:0] exc = '0, epc = '0;
  logic [5:0]  stall;
  logic        flush, stall_timeout;
  logic [31:0] new_pc, stall_cycles;
  int          checks = 0, errors = 0;
  logic [31:0] sc_exp = '0;
  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (id),
    .stallreq_from_ex (ex),
    .stallreq_from_mem(mem),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout),
    .stall_cycles     (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic i_id, input logic i_ex,
                     input logic i_mem, input logic [31:0] i_exc, input logic [31:0] i_epc,
                     input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                     input logic e_to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id = i_id; ex = i_ex; mem = i_mem; exc = i_exc; epc = i_epc;
    q.push_back('{e_stall, e_flush, e_pc, e_to});
    @(negedge clk);
    e = q.pop_front();
    check({tag, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
    check({tag, ".new_pc"}, new_pc, e.pc);
    check({tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, e.to});
    check({tag, ".cycles"}, stall_cycles, sc_exp);
    check({tag, ".excl"}, {31'd0, flush && |stall}, 32'd0);
    sc_exp = r ? 32'd0 : sc_exp + ((e_stall != 6'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    cyc("rst0", 1, 1, 1, 1, 32'h1, 32'h55, 6'h00, 0, 0, 0);
    cyc("rst1", 1, 0, 1, 0, 32'he, 32'h77, 6'h00, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("id",   0, 1, 0, 0, 0, 0, 6'h07, 0, 0, 0);
    cyc("ex",   0, 0, 1, 0, 0, 0, 6'h0f, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc("exid", 0, 1, 1, 0, 0, 0, 6'h0f, 0, 0, 0);
    cyc("mem",  0, 1, 1, 1, 0, 0, 6'h1f, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    // ERET redirects immediately, then one refill bubble that ignores everything
    cyc("eret",   0, 0, 0, 0, 32'he, 32'h1234, 6'h00, 1, 32'h1234, 0);
    cyc("eret_b", 0, 1, 1, 1, 32'he, 32'h1234, 6'h00, 0, 0, 0);
    cyc("run",    0, 1, 0, 0, 0, 0, 6'h07, 0, 0, 0);
    cyc("sys",    0, 1, 1, 0, 32'h8, 0, 6'h00, 1, 32'h40, 0);
    cyc("sys_b",  0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("ri",     0, 0, 0, 0, 32'ha, 0, 6'h00, 1, 32'h40, 0);
    cyc("ri_b",   0, 0, 0, 0, 32'ha, 0, 6'h00, 0, 0, 0);
    cyc("ov",     0, 0, 1, 0, 32'hc, 0, 6'h00, 1, 32'h40, 0);
    cyc("ov_b",   0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("trap",   0, 0, 0, 0, 32'hd, 0, 6'h00, 1, 32'h40, 0);
    cyc("trap_b", 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("other",  0, 0, 0, 0, 32'h5, 0, 6'h00, 1, 32'h40, 0);
    cyc("oth_b",  0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("int",    0, 1, 0, 0, 32'h1, 0, 6'h00, 1, 32'h20, 0);
    cyc("int_b",  0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    // interrupt deferred behind a memory stall; a later code arriving in PEND is ignored
    cyc("pend0",  0, 0, 0, 1, 32'h1, 0, 6'h1f, 0, 0, 0);
    cyc("pend1",  0, 0, 0, 1, 32'h8, 0, 6'h1f, 0, 0, 0);
    cyc("pend2",  0, 1, 1, 1, 0, 0, 6'h1f, 0, 0, 0);
    cyc("pendf",  0, 0, 0, 0, 32'h8, 0, 6'h00, 1, 32'h20, 0);
    cyc("pend_b", 0, 1, 0, 1, 0, 0, 6'h00, 0, 0, 0);
    cyc("idle",   0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("epend0", 0, 0, 0, 1, 32'he, 32'habcd, 6'h1f, 0, 0, 0);
    cyc("ependf", 0, 0, 0, 0, 0, 32'h9999, 6'h00, 1, 32'habcd, 0);
    cyc("epnd_b", 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    // reset while pending discards the exception
    cyc("rpend",  0, 0, 0, 1, 32'h1, 0, 6'h1f, 0, 0, 0);
    cyc("rpndr",  1, 0, 0, 1, 32'h1, 0, 6'h00, 0, 0, 0);
    cyc("rpnd1",  0, 1, 0, 0, 0, 0, 6'h07, 0, 0, 0);
    cyc("rpnd2",  0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("rpnd3",  0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    for (int i = 0; i < 1100; i++) cyc("wdog", 0, 1, 0, 0, 0, 0, 6'h07, 0, 0, i == 1023);
    cyc("end", 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("end", 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter INT_VECTOR, default 32'h0000_0020, handler address for interrupts.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0040, handler address for all other non-ERET exceptions.
REQ-003 Parameter WDOG_LIMIT, default 16'd1024, number of consecutive stalled cycles that raises stall_timeout.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stallreq_from_id  input  1  decode requests a stall (load-use hazard).
REQ-007 stallreq_from_ex  input  1  execute requests a stall (multi-cycle madd/msub/div).
REQ-008 stallreq_from_mem  input  1  memory stage waits on the bus.
REQ-009 excepttype_i  input  32  exception code from the memory stage; 0 means none.
REQ-010 cp0_epc_i  input  32  current CP0 EPC value.
REQ-011 stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-012 flush  output  1  clears all pipeline registers this cycle.
REQ-013 new_pc  output  32  redirect target; valid only while flush=1, else 0.
REQ-014 stall_timeout  output  1  one-cycle pulse on watchdog expiry.
REQ-015 stall_cycles  output  32  saturating count of cycles with any stall bit set.

Function
REQ-016 stall SHALL be combinational from current inputs and state, zero-cycle latency.
REQ-017 Stall priority SHALL be mem > ex > id: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, none -> 6'b000000.
REQ-018 Exception mapping SHALL be: 32'h1 -> INT_VECTOR; 32'h8, 32'ha, 32'hc, 32'hd -> EXC_VECTOR; 32'he (ERET) -> cp0_epc_i; any other nonzero code -> EXC_VECTOR.
REQ-019 Three-state FSM SHALL be used: RUN, PEND, FLUSH.
REQ-020 RUN, excepttype_i!=0, stallreq_from_mem=0: flush=1, stall=0, new_pc per REQ-018 in the same cycle; next state FLUSH.
REQ-021 RUN, excepttype_i!=0, stallreq_from_mem=1: latch code and target (EPC sampled this cycle), flush=0, stall=6'b011111; next state PEND.
REQ-022 PEND: stall=6'b011111 while stallreq_from_mem=1; on the first cycle it is 0, flush=1, new_pc=latched target, stall=0; next state FLUSH.
REQ-023 In PEND, a new excepttype_i SHALL be ignored; the latched exception is taken.
REQ-024 FLUSH SHALL last exactly one cycle: flush=0, stall=0 and exceptions ignored regardless of inputs (refill bubble); next state RUN.
REQ-025 Exceptions SHALL override id/ex stall requests in the same cycle.
REQ-026 Watchdog counter (16-bit) SHALL increment each cycle stall!=0, clear when stall==0; on reaching WDOG_LIMIT, pulse stall_timeout for one cycle and clear.
REQ-027 stall_cycles SHALL increment each cycle stall!=0 and hold at 32'hFFFF_FFFF.
REQ-028 flush and any stall bit SHALL never be 1 in the same cycle.

Reset
REQ-029 On rst=1: state RUN, latched code/target 0, watchdog 0, stall_cycles 0, stall_timeout 0.
REQ-030 While rst=1: stall=0, flush=0, new_pc=0 regardless of inputs.
REQ-031 rst during PEND SHALL discard the pending exception.

Structure
REQ-032 Stall encodings, exception codes (1, 8, a, c, d, e), and the FSM state encoding SHALL live in the shared defines package.
REQ-033 The watchdog and stall_cycles counters SHALL be one sub-module, stall_monitor; the FSM stays in pipe_ctrl.

Verification
REQ-034 stallreq_from_ex=1, stallreq_from_id=1 -> stall=6'b001111, flush=0; stall_cycles +1 per cycle.
REQ-035 excepttype_i=32'he, cp0_epc_i=32'h0000_1234, no mem stall -> same cycle flush=1, new_pc=32'h0000_1234; next cycle flush=0, stall=0.
REQ-036 excepttype_i=32'h1 with stallreq_from_mem=1 for 3 cycles -> stall=6'b011111 for 3 cycles, then flush=1, new_pc=32'h20 for one cycle.
REQ-037 In PEND, assert excepttype_i=32'h8 while latched 32'h1 -> new_pc=32'h20 on release.
REQ-038 stallreq_from_id held 1024 cycles -> stall_timeout pulses once at cycle 1024; watchdog restarts.
REQ-039 rst asserted in PEND -> next cycle flush=0, stall per inputs; no deferred flush after release.
